// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: FETCH/DECODE/EXEC/HALT sequencer with a single-port
// request/acknowledge memory interface, zero/carry flags and a registered I/O port.
module acc_cpu_core #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  localparam int A_W   = WORD_W - OP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [A_W-1:0]    mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] io_in,
  output logic [WORD_W-1:0] io_out,
  output logic [WORD_W-1:0] acc,
  output logic [A_W-1:0]    pc,
  output logic              z_flag,
  output logic              c_flag,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BZ    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SYS   = OP_W'(7);

  state_t              state_q, state_d;
  logic [A_W-1:0]      pc_q, pc_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [WORD_W-1:0]   ir_q, ir_d;
  logic [WORD_W-1:0]   io_out_q, io_out_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic                fetch_pend_q, fetch_pend_d;

  logic                req, we;
  logic [OP_W-1:0]     opc;
  logic [A_W-1:0]      operand;
  logic [1:0]          sys_sub;
  logic                is_mem_op;
  logic [WORD_W:0]     sum, diff, inc;

  assign opc       = ir_q[WORD_W-1 -: OP_W];
  assign operand   = ir_q[A_W-1:0];
  assign sys_sub   = ir_q[1:0];
  assign is_mem_op = (opc < OP_W'(5));

  // Extra top bit carries the ADD/INC carry-out and the SUB borrow.
  assign sum  = {1'b0, acc_q} + {1'b0, mem_rdata};
  assign diff = {1'b0, acc_q} - {1'b0, mem_rdata};
  assign inc  = {1'b0, acc_q} + (WORD_W+1)'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    acc_d        = acc_q;
    ir_d         = ir_q;
    io_out_d     = io_out_q;
    z_d          = z_q;
    c_d          = c_q;
    fetch_pend_d = 1'b0;
    req          = 1'b0;
    we           = 1'b0;
    mem_addr     = pc_q;

    case (state_q)
      S_FETCH: begin
        // A fetch already on the bus stays requested even if run drops.
        req = run | fetch_pend_q;
        if (req) begin
          if (mem_ack) begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + A_W'(1);
            state_d = S_DECODE;
          end else begin
            fetch_pend_d = 1'b1;
          end
        end
      end

      S_DECODE: begin
        if (opc == OP_SYS && sys_sub == 2'd0) state_d = S_HALT;
        else                                  state_d = S_EXEC;
      end

      S_EXEC: begin
        mem_addr = operand;
        if (is_mem_op) begin
          req = 1'b1;
          we  = (opc == OP_STORE);
          if (mem_ack) begin
            case (opc)
              OP_LOAD: begin
                acc_d = mem_rdata;
                z_d   = (mem_rdata == '0);
              end
              OP_ADD: begin
                {c_d, acc_d} = sum;
                z_d          = (sum[WORD_W-1:0] == '0);
              end
              OP_SUB: begin
                {c_d, acc_d} = diff;
                z_d          = (diff[WORD_W-1:0] == '0);
              end
              OP_XOR: begin
                acc_d = acc_q ^ mem_rdata;
                z_d   = ((acc_q ^ mem_rdata) == '0);
              end
              default: ;
            endcase
            state_d = S_FETCH;
          end
        end else begin
          case (opc)
            OP_BZ:  if (z_q) pc_d = operand;
            OP_JMP: pc_d = operand;
            OP_SYS: begin
              case (sys_sub)
                2'd1: begin
                  acc_d = io_in;
                  z_d   = (io_in == '0);
                end
                2'd2: io_out_d = acc_q;
                2'd3: begin
                  {c_d, acc_d} = inc;
                  z_d          = (inc[WORD_W-1:0] == '0);
                end
                default: ;
              endcase
            end
            default: ;
          endcase
          state_d = S_FETCH;
        end
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      acc_q        <= '0;
      ir_q         <= '0;
      io_out_q     <= '0;
      z_q          <= 1'b1;
      c_q          <= 1'b0;
      fetch_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      acc_q        <= acc_d;
      ir_q         <= ir_d;
      io_out_q     <= io_out_d;
      z_q          <= z_d;
      c_q          <= c_d;
      fetch_pend_q <= fetch_pend_d;
    end
  end

  // Requests are suppressed while reset is held so no access can start.
  assign mem_req   = req & ~reset;
  assign mem_we    = we & ~reset;
  assign mem_wdata = acc_q;
  assign io_out    = io_out_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign z_flag    = z_q;
  assign c_flag    = c_q;
  assign halted    = (state_q == S_HALT);

endmodule
